exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
Exception/interrupt sequencer between the MEM stage and the CP0 register file. Samples the MEM-stage instruction's exception flags, pending interrupts and ERET, picks one event by fixed priority, and drives the CP0 write-side signals (en_exp, exp_*, clean_exl). It then flushes the pipeline and issues a single redirect PC to fetch. It is the sole source of CP0 exception commits and of exception/ERET fetch redirects.

Parameters:
BOOT_VEC, 32'hBFC00380, handler address used when boot_exp_vec=1
EXC_OFFSET, 12'h180, offset appended to ebase when boot_exp_vec=0
FLUSH_CYCLES, 2, cycles flush is held (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
commit_en  in  1  pipeline advance; CP0 samples writes only when high
mem_valid  in  1  MEM-stage instruction valid
mem_pc  in  32  MEM-stage PC
mem_bd  in  1  MEM instruction is in a delay slot
mem_exc  in  7  flags: [0]fetch AdEL [1]RI [2]Ov [3]Sys [4]Bp [5]load AdEL [6]store AdES
mem_eret  in  1  MEM instruction is ERET
mem_bad_addr  in  32  data address for [5]/[6]
allow_int, int_exl  in  1 each  CP0 Status IE-enabled / EXL
interrupt_mask  in  8  Status.IM
software_int  in  2  Cause.IP[1:0]
hardware_int  in  6  Cause.IP[7:2]
ebase  in  20  exception base [31:12]
boot_exp_vec  in  1  Status.BEV
epc  in  32  CP0 EPC
redirect_ready  in  1  fetch accepts redirect
en_exp, exp_bd, exp_badv_we, clean_exl  out  1 each  CP0 commit controls
exp_epc, exp_bad_vaddr  out  32  CP0 commit data
exp_code  out  5  ExcCode
flush  out  1  kill IF..MEM contents
redirect_valid  out  1  redirect_pc valid
redirect_pc  out  32  new fetch PC
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs registered. Reset: state=IDLE and every output 0, asserted immediately on rst low, including mid-sequence; no partial commit survives reset.
- int_pend = allow_int & ~int_exl & |(interrupt_mask & {hardware_int, software_int}).
- Trigger in IDLE when commit_en & mem_valid & (int_pend | |mem_exc | mem_eret). Triggers are ignored when mem_valid=0 or when not in IDLE.
- Priority, highest first, with code and BadVAddr:
  - Int 0x00, no BadVAddr write
  - fetch AdEL 0x04, BadVAddr=mem_pc
  - RI 0x0a
  - Ov 0x0c
  - Sys 0x08
  - Bp 0x09
  - load AdEL 0x04, BadVAddr=mem_bad_addr
  - store AdES 0x05, BadVAddr=mem_bad_addr
  - ERET, lowest; taken only if no other event
- Latched at the trigger edge: exp_epc = mem_bd ? mem_pc-4 : mem_pc (32-bit wrap); exp_bd = mem_bd; code; BadVAddr and its write enable.
- Redirect target, latched at the same edge: exception -> boot_exp_vec ? BOOT_VEC : {ebase, EXC_OFFSET}; ERET -> epc.
- States:
  - IDLE: trigger -> COMMIT.
  - COMMIT: en_exp=1 (exception) or clean_exl=1 (ERET); the other stays 0. Held until a cycle with commit_en=1; the next cycle goes to FLUSH with en_exp/clean_exl dropped. Exactly one commit_en-qualified cycle of assertion.
  - FLUSH: flush=1 for FLUSH_CYCLES cycles (4-bit down-counter), then REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc stable, flush=0. On redirect_ready=1, go to IDLE; redirect_valid drops the next cycle.
- Simultaneous interrupt and exception flags: the interrupt wins and code=0. Simultaneous exception and ERET: the exception wins and clean_exl is never asserted.
- Minimum sequence: trigger T, en_exp T+1, flush T+2..T+1+FLUSH_CYCLES, redirect_valid T+2+FLUSH_CYCLES.

Test Plan:
- Reset, then mem_valid=1, mem_exc=7'b0000010 (RI), mem_pc=0xBFC00010, mem_bd=0, boot_exp_vec=1, commit_en=1 always, redirect_ready=1 -> en_exp=1 one cycle with exp_code=0x0a, exp_epc=0xBFC00010, exp_badv_we=0; flush=1 two cycles; redirect_pc=0xBFC00380.
- Store AdES, mem_bd=1, mem_pc=0x80001004, mem_bad_addr=0x00000003, boot_exp_vec=0, ebase=0x80000 -> exp_code=0x05, exp_epc=0x80001000, exp_bd=1, exp_bad_vaddr=0x00000003, redirect_pc=0x80000180.
- allow_int=1, int_exl=0, interrupt_mask=0x04, hardware_int=6'b000001, plus mem_exc[2]=1 (Ov) -> exp_code=0x00; the Ov flag is not reported.
- mem_eret=1 with epc=0xBFC00720 and no exceptions -> clean_exl=1 and en_exp=0; redirect_pc=0xBFC00720.
- Hold commit_en=0 for 3 cycles while in COMMIT -> en_exp stays high; flush does not start until the first commit_en=1 cycle.
- Pull rst low during FLUSH, then release -> all outputs 0 immediately, busy=0; the next trigger runs the full sequence normally.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 / fetch signal bundle for the exception sequencer.
interface exc_ctrl_if;
    logic        commit_en;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [6:0]  mem_exc;
    logic        mem_eret;
    logic [31:0] mem_bad_addr;
    logic        allow_int;
    logic        int_exl;
    logic [7:0]  interrupt_mask;
    logic [1:0]  software_int;
    logic [5:0]  hardware_int;
    logic [19:0] ebase;
    logic        boot_exp_vec;
    logic [31:0] epc;
    logic        redirect_ready;

    logic        en_exp;
    logic        exp_bd;
    logic        exp_badv_we;
    logic        clean_exl;
    logic [31:0] exp_epc;
    logic [31:0] exp_bad_vaddr;
    logic [4:0]  exp_code;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output commit_en, mem_valid, mem_pc, mem_bd, mem_exc, mem_eret, mem_bad_addr,
               allow_int, int_exl, interrupt_mask, software_int, hardware_int,
               ebase, boot_exp_vec, epc, redirect_ready,
        input  en_exp, exp_bd, exp_badv_we, clean_exl, exp_epc, exp_bad_vaddr,
               exp_code, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  commit_en, mem_valid, mem_pc, mem_bd, mem_exc, mem_eret, mem_bad_addr,
               allow_int, int_exl, interrupt_mask, software_int, hardware_int,
               ebase, boot_exp_vec, epc, redirect_ready,
        output en_exp, exp_bd, exp_badv_we, clean_exl, exp_epc, exp_bad_vaddr,
               exp_code, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt/ERET sequencer: picks one event, commits it to CP0,
// flushes the pipeline and issues a single fetch redirect.
module exc_ctrl #(
    parameter logic [31:0] BOOT_VEC     = 32'hBFC00380,
    parameter logic [11:0] EXC_OFFSET   = 12'h180,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    exc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        is_eret;
    logic        int_pend, trig, take, sel_eret, eret_n;
    logic [4:0]  code_c;
    logic [31:0] badv_c;
    logic        badv_we_c;

    // Fixed-priority event select; ERET only when nothing else is pending.
    always_comb begin
        int_pend  = bus.allow_int & ~bus.int_exl &
                    (|(bus.interrupt_mask & {bus.hardware_int, bus.software_int}));
        trig      = bus.commit_en & bus.mem_valid & (int_pend | (|bus.mem_exc) | bus.mem_eret);
        code_c    = 5'h00;
        badv_c    = 32'h0;
        badv_we_c = 1'b0;
        sel_eret  = 1'b0;
        if (int_pend)             code_c = 5'h00;
        else if (bus.mem_exc[0]) begin
            code_c = 5'h04; badv_c = bus.mem_pc; badv_we_c = 1'b1;
        end
        else if (bus.mem_exc[1])  code_c = 5'h0a;
        else if (bus.mem_exc[2])  code_c = 5'h0c;
        else if (bus.mem_exc[3])  code_c = 5'h08;
        else if (bus.mem_exc[4])  code_c = 5'h09;
        else if (bus.mem_exc[5]) begin
            code_c = 5'h04; badv_c = bus.mem_bad_addr; badv_we_c = 1'b1;
        end
        else if (bus.mem_exc[6]) begin
            code_c = 5'h05; badv_c = bus.mem_bad_addr; badv_we_c = 1'b1;
        end
        else                      sel_eret = 1'b1;
    end

    always_comb begin
        state_n = state;
        take    = (state == IDLE) && trig;
        eret_n  = take ? sel_eret : is_eret;
        case (state)
            IDLE:     if (trig)               state_n = COMMIT;
            COMMIT:   if (bus.commit_en)      state_n = FLUSH;
            FLUSH:    if (cnt == 4'd0)        state_n = REDIRECT;
            REDIRECT: if (bus.redirect_ready) state_n = IDLE;
            default:                          state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt                <= 4'd0;
            is_eret            <= 1'b0;
            bus.en_exp         <= 1'b0;
            bus.clean_exl      <= 1'b0;
            bus.exp_bd         <= 1'b0;
            bus.exp_badv_we    <= 1'b0;
            bus.exp_epc        <= 32'h0;
            bus.exp_bad_vaddr  <= 32'h0;
            bus.exp_code       <= 5'h0;
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'h0;
            bus.busy           <= 1'b0;
        end else begin
            if (take) begin
                is_eret           <= sel_eret;
                bus.exp_bd        <= bus.mem_bd;
                bus.exp_epc       <= bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
                bus.exp_code      <= code_c;
                bus.exp_bad_vaddr <= badv_c;
                bus.exp_badv_we   <= badv_we_c;
                bus.redirect_pc   <= sel_eret ? bus.epc :
                                     (bus.boot_exp_vec ? BOOT_VEC : {bus.ebase, EXC_OFFSET});
            end
            if (state != FLUSH)  cnt <= 4'(FLUSH_CYCLES - 1);
            else if (cnt != 4'd0) cnt <= cnt - 4'd1;
            bus.en_exp         <= (state_n == COMMIT) && !eret_n;
            bus.clean_exl      <= (state_n == COMMIT) && eret_n;
            bus.flush          <= (state_n == FLUSH);
            bus.redirect_valid <= (state_n == REDIRECT);
            bus.busy           <= (state_n != IDLE);
        end
    end
endmodule
